alphamission_side_pixel_mixer: RTL

- Downstream of the side (scroll) layer stage; consumes its 4-bit per-pixel colour nibble SD.
- Delays SD by a runtime-programmable number of pixels to align it with the sprite layer, applies the CPU-set side colour bank and layer enable, and resolves side/sprite priority.
- Produces the registered 8-bit palette address that feeds the colour RAM lookup.

---
 rtl/alphamission_side_pixel_mixer_if.sv | 25 ++
 rtl/alphamission_side_pixel_mixer.sv | 91 +++++++++
 2 files changed

// File: rtl/alphamission_side_pixel_mixer_if.sv
// Pixel-side bus of the side-layer mixer: pixel inputs, CPU control write and palette output.
interface alphamission_side_pixel_mixer_if #(
    parameter int unsigned PW = 4
);
    logic          pix_ce;
    logic          blank;
    logic [3:0]    sd;
    logic [PW-1:0] dly;
    logic [6:0]    spr_col;
    logic          spr_opq;
    logic          cpu_wr;
    logic [7:0]    cpu_din;
    logic [7:0]    col_addr;
    logic [1:0]    col_src;

    modport master (
        output pix_ce, blank, sd, dly, spr_col, spr_opq, cpu_wr, cpu_din,
        input  col_addr, col_src
    );

    modport slave (
        input  pix_ce, blank, sd, dly, spr_col, spr_opq, cpu_wr, cpu_din,
        output col_addr, col_src
    );
endinterface

// File: rtl/alphamission_side_pixel_mixer.sv
// Side-layer alignment delay line, bank/enable control register and side/sprite priority
// mixer producing the registered palette address.
module alphamission_side_pixel_mixer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned PW    = 4
) (
    input  logic                           clk,
    input  logic                           VIDEO_RST,
    alphamission_side_pixel_mixer_if.slave bus
);
    typedef struct packed {
        logic       prio;
        logic       en;
        logic [2:0] bank;
    } ctl_t;

    localparam int unsigned CTL_W = $bits(ctl_t);

    ctl_t          ctl_q;
    ctl_t          ctl_eff;
    logic [3:0]    mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [3:0]    sdm;
    logic [3:0]    rd;
    logic          side_vis;
    logic          spr_vis;
    logic [7:0]    addr_d;
    logic [1:0]    src_d;
    logic [7:0]    addr_q;
    logic [1:0]    src_q;
    logic          unused_din;

    assign unused_din   = ^bus.cpu_din[7:5];
    assign bus.col_addr = addr_q;
    assign bus.col_src  = src_q;

    // A write landing on the same clk as a strobe is already visible to that strobe.
    always_comb begin
        ctl_eff = ctl_q;
        if (bus.cpu_wr) begin
            ctl_eff = ctl_t'(bus.cpu_din[CTL_W-1:0]);
        end
    end

    // Delay-line tap: zero delay bypasses the line with the current (blank-masked) sample.
    always_comb begin
        sdm  = bus.blank ? 4'h0 : bus.sd;
        rptr = wptr - PW'(bus.dly);
        rd   = (bus.dly == '0) ? sdm : mem[rptr];
    end

    always_comb begin
        side_vis = ctl_eff.en & (rd != 4'h0);
        spr_vis  = bus.spr_opq;
        addr_d   = 8'h00;
        src_d    = 2'b00;
        if (bus.blank) begin
            addr_d = 8'h00;
            src_d  = 2'b00;
        end else if (side_vis && (ctl_eff.prio || !spr_vis)) begin
            addr_d = {1'b1, ctl_eff.bank, rd};
            src_d  = 2'b10;
        end else if (spr_vis) begin
            addr_d = {1'b0, bus.spr_col};
            src_d  = 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (VIDEO_RST) begin
            wptr   <= '0;
            ctl_q  <= '0;
            addr_q <= 8'h00;
            src_q  <= 2'b00;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= 4'h0;
            end
        end else begin
            if (bus.cpu_wr) begin
                ctl_q <= ctl_t'(bus.cpu_din[CTL_W-1:0]);
            end
            if (bus.pix_ce) begin
                mem[wptr] <= sdm;
                wptr      <= wptr + PW'(1);
                addr_q    <= addr_d;
                src_q     <= src_d;
            end
        end
    end
endmodule
